multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Main control state machine for the multi-cycle MIPS datapath. Decodes the instruction register's opcode/funct and sequences one instruction over 3–5 cycles. Drives the datapath mux selects, the memory and register-file enables, and the `alu_op` code consumed by `alu`. Receives the `zero` flag back from `alu` to resolve `beq`.

## Interface
Parameters:
- none. Widths come from `defines.v`.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from the cycle after FETCH until the next FETCH.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `pc_en` out 1: PC load enable, computed as `pc_write | (pc_write_cond & zero)`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `ir_write` out 1: IR load enable.
- `reg_dst` out 1: write-register select; 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back data select; 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B select; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 4: ALU operation code; AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- `pc_source` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal_instr` out 1: one-cycle pulse in DECODE when the instruction is unsupported.
- `state` out 4: current state, for debug.

## Operation
- Supported instructions:
  - R-type (opcode 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
- Output behaviour:
  - Moore outputs decoded from `state`.
  - Exceptions: `alu_op` in EXECUTE depends on `funct`; `pc_en` in BRANCH depends on `zero`.
- Every output not listed for a state is 0, except `alu_op`, which defaults to ADD.
- States and transitions:
  - IDLE: all outputs 0, `alu_op` = 0000 → FETCH.
  - FETCH: `mem_read`, `ir_write`, `pc_write`; `alu_src_a` = 0, `alu_src_b` = 01, ADD → DECODE.
  - DECODE: `alu_src_a` = 0, `alu_src_b` = 11, ADD (precomputes branch target). Next state by opcode: lw/sw → MEM_ADDR, R-type → EXECUTE, beq → BRANCH, j → JUMP, addi → ADDI_EXEC. Unsupported opcode, or R-type with unsupported funct → pulse `illegal_instr` and `instr_done`, then → FETCH.
  - MEM_ADDR: `alu_src_a` = 1, `alu_src_b` = 10, ADD → MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ: `mem_read`, `iord` → MEM_WB.
  - MEM_WB: `reg_write`, `mem_to_reg`, `reg_dst` = 0, `instr_done` → FETCH.
  - MEM_WRITE: `mem_write`, `iord`, `instr_done` → FETCH.
  - EXECUTE: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = `alu_ctrl(funct)` → ALU_WB.
  - ALU_WB: `reg_write`, `reg_dst` = 1, `instr_done` → FETCH.
  - BRANCH: `alu_src_a` = 1, `alu_src_b` = 00, SUB, `pc_write_cond`, `pc_source` = 01, `instr_done` → FETCH.
  - JUMP: `pc_write`, `pc_source` = 10, `instr_done` → FETCH.
  - ADDI_EXEC: `alu_src_a` = 1, `alu_src_b` = 10, ADD → ADDI_WB.
  - ADDI_WB: `reg_write`, `reg_dst` = 0, `instr_done` → FETCH.
- There is no stall or handshake: memory is single-cycle. The FSM never waits.

## Timing
- Reset: `rst_n` low forces `state` = IDLE immediately (asynchronous), so every output is 0. The first FETCH occurs on the second rising edge after `rst_n` rises.
- Reset mid-instruction abandons the instruction. No partial writes occur after the asynchronous assertion.
- Cycles per instruction, FETCH through the `instr_done` state inclusive:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal 2
- `pc_en` in BRANCH is combinational on `zero` within the same cycle. `zero` toggling in any other state has no effect.
- `instr_done` and `illegal_instr` are each high for exactly one cycle per instruction.

## Structure
- `defines.v` holds:
  - opcode and funct constants;
  - ALU op codes `ALU_AND`/`ALU_OR`/`ALU_ADD`/`ALU_SUB`/`ALU_SLT`;
  - state encodings `S_IDLE`…`S_ADDI_WB` (4-bit, binary);
  - `alu_src_b` and `pc_source` select codes.
- One sub-module, `alu_ctrl`: combinational mapping funct → {`alu_op`, `funct_valid`}. It is reused by EXECUTE and by the DECODE legality check.

## Test plan
- Reset held 3 cycles, then released → `state` = IDLE with all outputs 0 during reset; `state` = FETCH one cycle after release, with `pc_en` = 1, `ir_write` = 1, `alu_src_b` = 01.
- lw (opcode 0x23) → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. `reg_write` = 1 with `mem_to_reg` = 1 only in cycle 5; `instr_done` pulses in cycle 5.
- R-type with funct 0x22, then 0x2A → `alu_op` = 0110, then 0111, in EXECUTE; `reg_dst` = 1 in ALU_WB; 4 cycles each.
- beq with `zero` = 1, then `zero` = 0 → `pc_en` = 1, then 0, in BRANCH; `pc_source` = 01; 3 cycles each.
- opcode 0x3F, and R-type funct 0x27 → `illegal_instr` pulses in DECODE; next state FETCH; no `reg_write`/`mem_write` asserted.
- `rst_n` dropped during MEM_READ of lw → immediate IDLE; MEM_WB never reached; `reg_write` stays 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, funct codes,
// ALU operation codes, FSM state encoding and datapath mux select codes.
package multi_cycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

endpackage

// File: rtl/multi_cycle_ctrl_alu_ctrl.sv
// R-type funct to ALU op decoder, also reporting whether the funct is supported.
// Purely combinational, no flow control.
module alu_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       funct_valid
);

    always_comb begin
        alu_op      = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: 3-5 cycles per instruction (2 for illegal ones).
// Never stalls; memory is single-cycle so there is no backpressure.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic       pc_write;
    logic       pc_write_cond;
    logic [3:0] funct_op;
    logic       funct_valid;

    alu_ctrl u_alu_ctrl (
        .funct       (funct),
        .alu_op      (funct_op),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        case (state_q)
            S_IDLE: begin
                alu_op  = ALU_AND;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = ALUB_FOUR;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut while decoding.
                alu_src_b = ALUB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_RTYPE: begin
                        if (funct_valid) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_instr = 1'b1;
                            instr_done    = 1'b1;
                            state_d       = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_instr = 1'b1;
                        instr_done    = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = funct_op;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                alu_op  = ALU_AND;
                state_d = S_IDLE;
            end
        endcase
    end

    // zero only reaches pc_en through pc_write_cond, which is set in BRANCH alone.
    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes the expected state and
// output vector for each cycle, a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

    localparam logic [3:0] ST_IDLE = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2,
                           ST_MADDR = 4'd3, ST_MREAD = 4'd4,  ST_MWB = 4'd5,
                           ST_MWRITE = 4'd6, ST_EXEC = 4'd7,  ST_ALUWB = 4'd8,
                           ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_AEXEC = 4'd11,
                           ST_AWB = 4'd12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, instr_done, illegal_instr;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op, state;

    multi_cycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .pc_en         (pc_en),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Order: pc_en iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write
    //        alu_src_a alu_src_b[2] alu_op[4] pc_source[2] instr_done illegal_instr
    logic [18:0] act;
    assign act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
                  illegal_instr};

    function automatic logic [18:0] pk(input logic pe, io, mr, mw, irw, rd, m2r, rw, sa,
                                       input logic [1:0] sb, input logic [3:0] ao,
                                       input logic [1:0] ps, input logic dn, il);
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, dn, il};
    endfunction

    typedef struct {
        logic [3:0]  st;
        logic [18:0] o;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [18:0] e_idle, e_fetch, e_decode, e_decode_ill, e_maddr, e_mread, e_mwb;
    logic [18:0] e_mwrite, e_alu_wb, e_jump, e_aexec, e_awb;

    function automatic logic [18:0] e_exec(input logic [3:0] ao);
        return pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ao, 2'b00, 0, 0);
    endfunction

    function automatic logic [18:0] e_branch(input logic z);
        return pk(z, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0110, 2'b01, 1, 0);
    endfunction

    // Monitor: one expected record per cycle, checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (state !== e.st) begin
                    failures++;
                    $display("FAIL %s state: got %0d expected %0d", e.nm, state, e.st);
                end
                checks++;
                if (act !== e.o) begin
                    failures++;
                    $display("FAIL %s outputs: got %b expected %b", e.nm, act, e.o);
                end
            end
        end
    end

    task automatic step(input string nm, input logic [3:0] st, input logic [18:0] o,
                        input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t e;
        @(posedge clk);
        #1;
        opcode = op;
        funct  = fn;
        zero   = z;
        e.st = st;
        e.o  = o;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic run_rtype(input string nm, input logic [5:0] fn, input logic [3:0] ao);
        step({nm, "_fetch"},  ST_FETCH,  e_fetch,    6'h00, fn, 1'b1);
        step({nm, "_decode"}, ST_DECODE, e_decode,   6'h00, fn, 1'b1);
        step({nm, "_exec"},   ST_EXEC,   e_exec(ao), 6'h00, fn, 1'b1);
        step({nm, "_wb"},     ST_ALUWB,  e_alu_wb,   6'h00, fn, 1'b1);
    endtask

    task automatic run_beq(input string nm, input logic z);
        step({nm, "_fetch"},  ST_FETCH,  e_fetch,     6'h04, 6'h00, ~z);
        step({nm, "_decode"}, ST_DECODE, e_decode,    6'h04, 6'h00, ~z);
        step({nm, "_branch"}, ST_BRANCH, e_branch(z), 6'h04, 6'h00, z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        e_idle       = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 0, 0);
        e_fetch      = pk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'b0010, 2'b00, 0, 0);
        e_decode     = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 2'b00, 0, 0);
        e_decode_ill = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 2'b00, 1, 1);
        e_maddr      = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 2'b00, 0, 0);
        e_mread      = pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 2'b00, 0, 0);
        e_mwb        = pk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'b0010, 2'b00, 1, 0);
        e_mwrite     = pk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 2'b00, 1, 0);
        e_alu_wb     = pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0010, 2'b00, 1, 0);
        e_jump       = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010, 2'b10, 1, 0);
        e_aexec      = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010, 2'b00, 0, 0);
        e_awb        = pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0010, 2'b00, 1, 0);

        rst_n  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;

        // Reset held for three cycles, released mid-cycle.
        repeat (3) step("reset", ST_IDLE, e_idle, 6'h23, 6'h00, 1'b0);
        rst_n = 1'b1;

        // lw: 5 cycles; zero high outside BRANCH must not move the PC.
        step("lw_fetch",  ST_FETCH,  e_fetch,  6'h23, 6'h00, 1'b1);
        step("lw_decode", ST_DECODE, e_decode, 6'h23, 6'h00, 1'b1);
        step("lw_maddr",  ST_MADDR,  e_maddr,  6'h23, 6'h00, 1'b1);
        step("lw_mread",  ST_MREAD,  e_mread,  6'h23, 6'h00, 1'b1);
        step("lw_mwb",    ST_MWB,    e_mwb,    6'h23, 6'h00, 1'b1);

        step("sw_fetch",  ST_FETCH,  e_fetch,  6'h2B, 6'h00, 1'b0);
        step("sw_decode", ST_DECODE, e_decode, 6'h2B, 6'h00, 1'b0);
        step("sw_maddr",  ST_MADDR,  e_maddr,  6'h2B, 6'h00, 1'b0);
        step("sw_mwrite", ST_MWRITE, e_mwrite, 6'h2B, 6'h00, 1'b0);

        run_rtype("sub", 6'h22, 4'b0110);
        run_rtype("slt", 6'h2A, 4'b0111);
        run_rtype("and", 6'h24, 4'b0000);
        run_rtype("or",  6'h25, 4'b0001);
        run_rtype("add", 6'h20, 4'b0010);

        run_beq("beq_taken", 1'b1);
        run_beq("beq_not",   1'b0);

        step("j_fetch",  ST_FETCH,  e_fetch,  6'h02, 6'h00, 1'b0);
        step("j_decode", ST_DECODE, e_decode, 6'h02, 6'h00, 1'b0);
        step("j_jump",   ST_JUMP,   e_jump,   6'h02, 6'h00, 1'b0);

        step("addi_fetch",  ST_FETCH,  e_fetch,  6'h08, 6'h00, 1'b1);
        step("addi_decode", ST_DECODE, e_decode, 6'h08, 6'h00, 1'b1);
        step("addi_exec",   ST_AEXEC,  e_aexec,  6'h08, 6'h00, 1'b1);
        step("addi_wb",     ST_AWB,    e_awb,    6'h08, 6'h00, 1'b1);

        step("ill_op_fetch",  ST_FETCH,  e_fetch,      6'h3F, 6'h00, 1'b0);
        step("ill_op_decode", ST_DECODE, e_decode_ill, 6'h3F, 6'h00, 1'b0);
        step("ill_fn_fetch",  ST_FETCH,  e_fetch,      6'h00, 6'h27, 1'b0);
        step("ill_fn_decode", ST_DECODE, e_decode_ill, 6'h00, 6'h27, 1'b0);

        // lw abandoned by asynchronous reset during MEM_READ.
        step("lwr_fetch",  ST_FETCH,  e_fetch,  6'h23, 6'h00, 1'b0);
        step("lwr_decode", ST_DECODE, e_decode, 6'h23, 6'h00, 1'b0);
        step("lwr_maddr",  ST_MADDR,  e_maddr,  6'h23, 6'h00, 1'b0);
        step("lwr_mread",  ST_MREAD,  e_mread,  6'h23, 6'h00, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== ST_IDLE || act !== e_idle) begin
            failures++;
            $display("FAIL async_reset: state=%0d out=%b expected state=%0d out=%b",
                     state, act, ST_IDLE, e_idle);
        end
        step("lwr_held", ST_IDLE, e_idle, 6'h23, 6'h00, 1'b0);
        rst_n = 1'b1;

        step("post_fetch",  ST_FETCH,  e_fetch,  6'h02, 6'h00, 1'b0);
        step("post_decode", ST_DECODE, e_decode, 6'h02, 6'h00, 1'b0);
        step("post_jump",   ST_JUMP,   e_jump,   6'h02, 6'h00, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
